instrumented_adder_wrapper: RTL and testbench

- Behavioural, fully synchronous model of the instrumented-adder user project.
- A 32-bit adder is closed into a feedback loop through a registered chain bit, which stands in for the silicon ring oscillator; a 32-bit counter counts loop oscillations.
- Operands, bit masks and commands arrive on logic-analyser (LA) lanes; results return on LA and IO.
- The `active` input gates the outputs, replacing the wrapper's tristates with 0.

---
 rtl/instrumented_adder_wrapper.sv | 107 ++++++++++
 tb/tb_instrumented_adder_wrapper.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instrumented_adder_wrapper.sv
// Synchronous behavioural model of the instrumented-adder user project: a 32-bit adder
// closed into a ring through a registered chain bit, with an oscillation counter.
module instrumented_adder_wrapper (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        active,
    input  logic [31:0] la1_data_in,
    input  logic [31:0] la2_data_in,
    input  logic [31:0] la3_data_in,
    input  logic [31:0] la1_oenb,
    input  logic [31:0] la2_oenb,
    input  logic [31:0] la3_oenb,
    input  logic [37:0] io_in,
    output logic [31:0] la1_data_out,
    output logic [31:0] la2_data_out,
    output logic [31:0] la3_data_out,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);
    logic [31:0] cmd;
    logic        run;

    logic [31:0] a_input_q, a_input_d;
    logic [31:0] b_input_q, b_input_d;
    logic [31:0] ring_b_q, ring_b_d;
    logic [31:0] ext_b_q, ext_b_d;
    logic [31:0] out_b_q, out_b_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] sum_q, sum_d;
    logic        carry_q, carry_d;
    logic        chain_out_q, chain_out_d;
    logic        chain_prev_q, chain_prev_d;

    logic [31:0] a_eff;
    logic [32:0] sum;
    logic        chain_src;

    // A command bit only counts when the project is selected and its lane is qualified.
    assign cmd = {32{active}} & la3_data_in & ~la3_oenb;
    assign run = cmd[5];

    // Per-bit operand source: ring feedback, external pin, or the loaded A word.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_a_eff
            assign a_eff[gi] = !ring_b_q[gi] ? ~chain_out_q :
                               !ext_b_q[gi]  ? io_in[8]     :
                                               a_input_q[gi];
        end
    endgenerate

    assign sum       = {1'b0, a_eff} + {1'b0, b_input_q};
    assign chain_src = |(sum[31:0] & ~out_b_q);

    always_comb begin
        a_input_d    = cmd[0] ? la1_data_in : a_input_q;
        b_input_d    = cmd[1] ? la2_data_in : b_input_q;
        ring_b_d     = cmd[2] ? la1_data_in : ring_b_q;
        ext_b_d      = cmd[3] ? la1_data_in : ext_b_q;
        out_b_d      = cmd[4] ? la1_data_in : out_b_q;
        chain_out_d  = run ? chain_src : 1'b0;
        chain_prev_d = chain_out_q;
        counter_d    = counter_q;
        if (cmd[6]) begin
            counter_d = '0;
        end else if (run && chain_out_q && !chain_prev_q) begin
            counter_d = counter_q + 32'd1;
        end
        // The captured result freezes while the loop is running.
        sum_d   = run ? sum_q   : sum[31:0];
        carry_d = run ? carry_q : sum[32];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            a_input_q    <= '0;
            b_input_q    <= '0;
            ring_b_q     <= '0;
            ext_b_q      <= '0;
            out_b_q      <= 32'h3FFF_FFFF;
            counter_q    <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            chain_out_q  <= 1'b0;
            chain_prev_q <= 1'b0;
        end else begin
            a_input_q    <= a_input_d;
            b_input_q    <= b_input_d;
            ring_b_q     <= ring_b_d;
            ext_b_q      <= ext_b_d;
            out_b_q      <= out_b_d;
            counter_q    <= counter_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            chain_out_q  <= chain_out_d;
            chain_prev_q <= chain_prev_d;
        end
    end

    assign la1_data_out = active ? counter_q : '0;
    assign la2_data_out = active ? sum_q     : '0;
    assign la3_data_out = active ? {29'b0, carry_q, run, chain_out_q} : '0;
    assign io_out       = active ? {27'b0, run, chain_out_q, 9'b0} : '0;
    assign io_oeb       = active ? 38'h3F_FFFF_F9FF : '0;

    logic unused_inputs;
    assign unused_inputs = ^{la1_oenb, la2_oenb, io_in[37:9], io_in[7:0], cmd[31:7]};
endmodule

// File: tb/tb_instrumented_adder_wrapper.sv
// Directed and randomized checks of instrumented_adder_wrapper against a cycle-level
// reference model of the adder ring, masks and oscillation counter.
module tb_instrumented_adder_wrapper;
    logic        clk = 1'b0;
    logic        rst;
    logic        act;
    logic [31:0] la1_in, la2_in, la3_in;
    logic [31:0] la1_oenb, la2_oenb, la3_oenb;
    logic [37:0] io_in;
    logic [31:0] la1_out, la2_out, la3_out;
    logic [37:0] io_out, io_oeb;

    int n_total = 0;
    int n_bad   = 0;
    int n_txn   = 0;

    // Reference state
    logic [31:0] m_a, m_b, m_ring, m_ext, m_outb, m_cnt, m_sumq;
    logic        m_chain, m_prev, m_carry;

    always #5 clk = ~clk;

    instrumented_adder_wrapper dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .active       (act),
        .la1_data_in  (la1_in),
        .la2_data_in  (la2_in),
        .la3_data_in  (la3_in),
        .la1_oenb     (la1_oenb),
        .la2_oenb     (la2_oenb),
        .la3_oenb     (la3_oenb),
        .io_in        (io_in),
        .la1_data_out (la1_out),
        .la2_data_out (la2_out),
        .la3_data_out (la3_out),
        .io_out       (io_out),
        .io_oeb       (io_oeb)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance the reference by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] c, aeff;
        logic [32:0] s;
        logic        run, src;
        logic [31:0] n_cnt;
        c    = act ? (la3_in & ~la3_oenb) : 32'h0;
        run  = c[5];
        aeff = (~m_ring & {32{~m_chain}})
             | (m_ring & ~m_ext & {32{io_in[8]}})
             | (m_ring & m_ext & m_a);
        s    = 33'(aeff) + 33'(m_b);
        src  = (s[31:0] & ~m_outb) != 32'h0;
        if (rst) begin
            m_a = 0; m_b = 0; m_ring = 0; m_ext = 0; m_outb = 32'h3FFF_FFFF;
            m_cnt = 0; m_sumq = 0; m_carry = 0; m_chain = 0; m_prev = 0;
        end else begin
            n_cnt = m_cnt;
            if (c[6]) n_cnt = 0;
            else if (run && m_chain && !m_prev) n_cnt = m_cnt + 1;
            if (c[0]) m_a    = la1_in;
            if (c[1]) m_b    = la2_in;
            if (c[2]) m_ring = la1_in;
            if (c[3]) m_ext  = la1_in;
            if (c[4]) m_outb = la1_in;
            if (!run) begin
                m_sumq  = s[31:0];
                m_carry = s[32];
            end
            m_prev  = m_chain;
            m_chain = run ? src : 1'b0;
            m_cnt   = n_cnt;
        end
    endtask

    task automatic step(input logic r, input logic a, input logic [31:0] cmd,
                        input logic [31:0] d1, input logic [31:0] d2);
        logic        run_now;
        logic [31:0] e1, e2, e3;
        logic [37:0] eio, eoeb;
        rst = r; act = a; la3_in = cmd; la1_in = d1; la2_in = d2;
        @(posedge clk);
        model_edge();
        #1;
        run_now = act & la3_in[5] & ~la3_oenb[5];
        if (act) begin
            e1   = m_cnt;
            e2   = m_sumq;
            e3   = {29'b0, m_carry, run_now, m_chain};
            eio  = (38'(run_now) << 10) | (38'(m_chain) << 9);
            eoeb = 38'h3F_FFFF_FFFF ^ (38'd3 << 9);
        end else begin
            e1 = 0; e2 = 0; e3 = 0; eio = 0; eoeb = 0;
        end
        chk("la1_out", 64'(la1_out), 64'(e1));
        chk("la2_out", 64'(la2_out), 64'(e2));
        chk("la3_out", 64'(la3_out), 64'(e3));
        chk("io_out",  64'(io_out),  64'(eio));
        chk("io_oeb",  64'(io_oeb),  64'(eoeb));
        n_txn++;
        $display("txn %0d rst=%0d act=%0d cmd=%02h la1=%08h la2=%08h cnt=%08h sum=%08h st=%0h",
                 n_txn, r, a, cmd[6:0], d1, d2, la1_out, la2_out, la3_out[2:0]);
    endtask

    initial begin
        logic [31:0] cmd, d1;
        rst = 1; act = 1; la1_in = 0; la2_in = 0; la3_in = 0;
        la1_oenb = 0; la2_oenb = 0; la3_oenb = 0; io_in = 0;
        m_a = 0; m_b = 0; m_ring = 0; m_ext = 0; m_outb = 0;
        m_cnt = 0; m_sumq = 0; m_carry = 0; m_chain = 0; m_prev = 0;

        // Reset state
        step(1, 1, 0, 0, 0);
        chk("rst_cnt", 64'(la1_out), 64'h0);
        chk("rst_sum", 64'(la2_out), 64'h0);
        chk("rst_st",  64'(la3_out), 64'h0);
        chk("rst_oeb", 64'(io_oeb),  64'h3F_FFFF_F9FF);

        // Plain addition with all bits taken from the loaded A word
        step(0, 1, 32'h0C, 32'hFFFF_FFFF, 0);
        step(0, 1, 32'h03, 32'h5, 32'h3);
        step(0, 1, 0, 0, 0);
        chk("sum_8",   64'(la2_out), 64'h8);
        chk("carry_0", 64'(la3_out[2]), 64'h0);
        step(0, 1, 32'h03, 32'hFFFF_FFFF, 32'h1);
        step(0, 1, 0, 0, 0);
        chk("sum_wrap", 64'(la2_out), 64'h0);
        chk("carry_1",  64'(la3_out[2]), 64'h1);

        // Ring oscillation
        step(1, 1, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 32'h20, 0, 0);
            chk("ring_tog", 64'(io_out[9]), 64'(k % 2));
        end
        chk("ring_cnt5", 64'(la1_out), 64'd5);
        for (int k = 0; k < 4; k++) step(0, 1, 32'h20, 0, 0);
        chk("ring_cnt7", 64'(la1_out), 64'd7);
        step(0, 1, 32'h60, 0, 0);
        chk("clr_cnt", 64'(la1_out), 64'd0);
        step(0, 1, 32'h20, 0, 0);
        chk("clr_resume", 64'(la1_out), 64'd1);

        // Deselect mid-run
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 32'h7F, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            chk("inact_la1", 64'(la1_out), 64'h0);
            chk("inact_oeb", 64'(io_oeb), 64'h0);
        end
        step(0, 1, 32'h20, 0, 0);
        chk("react_frozen", 64'(la1_out), 64'd1);
        step(0, 1, 32'h20, 0, 0);
        step(0, 1, 32'h20, 0, 0);
        chk("react_inc", 64'(la1_out), 64'd2);

        // Reset wins over concurrent commands
        step(1, 1, 32'h7F, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("rstw_cnt", 64'(la1_out), 64'h0);
        chk("rstw_sum", 64'(la2_out), 64'h0);
        chk("rstw_chain", 64'(la3_out[0]), 64'h0);
        step(0, 1, 32'h20, 0, 0);
        chk("rstw_outb", 64'(io_out[9]), 64'h1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cmd = $urandom & 32'h7F;
            if ($urandom_range(0, 7) != 0) cmd[6] = 1'b0;
            if ($urandom_range(0, 2) != 0) cmd[5] = 1'b1;
            if ($urandom_range(0, 3) != 0) cmd[4:0] = 5'b0;
            cmd = cmd | ($urandom & 32'hFFFF_FF80);
            case ($urandom_range(0, 3))
                0: d1 = $urandom;
                1: d1 = 32'hFFFF_FFFF;
                2: d1 = 32'h0;
                default: d1 = 32'h3FFF_FFFF;
            endcase
            la3_oenb = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            la1_oenb = $urandom;
            la2_oenb = $urandom;
            io_in    = {$urandom, $urandom} & 38'h3F_FFFF_FFFF;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, cmd, d1, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
